// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the load/store port.
// Grants are made in the same cycle as the request, and each read response is routed back to its issuer.
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_bmask,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_bmask,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_stall,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_FETCH = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_state_e;

  localparam logic [3:0] RunLimit = 4'(MAX_DATA_RUN);

  rsp_state_e  rsp_q, rsp_d;
  logic [3:0]  data_run_q, data_run_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        run_full;

  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{if_addr[1:0], d_addr[1:0]};

  // Grants are forced low while reset is held so every output reads 0 during reset.
  assign run_full   = (data_run_q == RunLimit);
  assign if_gnt     = rst_n & if_req & (~d_req | run_full);
  assign d_gnt      = rst_n & d_req & ~if_gnt;
  assign core_stall = rst_n & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    mem_ce    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_bmask = 4'h0;
    if (if_gnt) begin
      mem_addr  = if_addr[AW-1:2];
      mem_bmask = 4'hF;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr[AW-1:2];
      mem_wdata = d_wdata;
      mem_bmask = d_bmask;
    end
  end

  always_comb begin
    data_run_d  = data_run_q;
    stall_cnt_d = stall_cnt_q + 32'(core_stall);
    if (!if_req || if_gnt) begin
      data_run_d = 4'd0;
    end else if (d_gnt && !run_full) begin
      data_run_d = data_run_q + 4'd1;
    end
  end

  // The response state only remembers who was granted a read this cycle.
  always_comb begin
    rsp_d = RSP_IDLE;
    if (if_gnt) begin
      rsp_d = RSP_FETCH;
    end else if (d_gnt && !d_we) begin
      rsp_d = RSP_DATA;
    end
  end

  always_comb begin
    if_rvalid = (rsp_q == RSP_FETCH);
    d_rvalid  = (rsp_q == RSP_DATA);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= RSP_IDLE;
      data_run_q  <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      rsp_q       <= rsp_d;
      data_run_q  <= data_run_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MaxRun = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_bmask;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_rdata;
  logic        core_stall;
  logic [31:0] stall_cnt;

  mem_port_arbiter #(.AW(16), .DW(32), .MAX_DATA_RUN(MaxRun)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_bmask(d_bmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bmask(mem_bmask), .mem_rdata(mem_rdata),
    .core_stall(core_stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small SRAM behind the arbiter; only the low word-address bits are decoded.
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_bmask[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[7:0]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: data grants in a row while fetch waits, the read
  // response owed next cycle (0 none, 1 fetch, 2 data), and the stall tally.
  int          refRun = 0;
  int          refPend = 0;
  logic [31:0] refPendData = '0;
  logic [31:0] refStallCnt = '0;
  logic        lastIfGnt, lastDGnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [15:0] iAddr,
                               input logic dReqV, input logic dWeV, input logic [15:0] dAddrV,
                               input logic [31:0] dWdataV, input logic [3:0] dBmaskV);
    logic expIf, expD, expStall;
    @(negedge clk);
    if_req = iReq; if_addr = iAddr;
    d_req = dReqV; d_we = dWeV; d_addr = dAddrV; d_wdata = dWdataV; d_bmask = dBmaskV;
    #2;
    expIf    = iReq && (!dReqV || refRun == MaxRun);
    expD     = dReqV && !expIf;
    expStall = (iReq && !expIf) || (dReqV && !expD);

    checkOutput("if_gnt", 64'(if_gnt), 64'(expIf));
    checkOutput("d_gnt", 64'(d_gnt), 64'(expD));
    checkOutput("mem_ce", 64'(mem_ce), 64'(expIf || expD));
    checkOutput("core_stall", 64'(core_stall), 64'(expStall));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(refStallCnt));
    if (expIf) begin
      checkOutput("mem_we_f", 64'(mem_we), 64'd0);
      checkOutput("mem_addr_f", 64'(mem_addr), 64'(iAddr >> 2));
      checkOutput("mem_bmask_f", 64'(mem_bmask), 64'hF);
    end else if (expD) begin
      checkOutput("mem_we_d", 64'(mem_we), 64'(dWeV));
      checkOutput("mem_addr_d", 64'(mem_addr), 64'(dAddrV >> 2));
      checkOutput("mem_bmask_d", 64'(mem_bmask), 64'(dBmaskV));
      checkOutput("mem_wdata_d", 64'(mem_wdata), 64'(dWdataV));
    end else begin
      checkOutput("mem_we_idle", 64'(mem_we), 64'd0);
      checkOutput("mem_bmask_idle", 64'(mem_bmask), 64'd0);
    end
    checkOutput("if_rvalid", 64'(if_rvalid), 64'(refPend == 1));
    checkOutput("if_rdata", 64'(if_rdata), (refPend == 1) ? 64'(refPendData) : 64'd0);
    checkOutput("d_rvalid", 64'(d_rvalid), 64'(refPend == 2));
    checkOutput("d_rdata", 64'(d_rdata), (refPend == 2) ? 64'(refPendData) : 64'd0);

    refPend = 0;
    if (expIf) begin
      refPend = 1; refPendData = sram[iAddr[9:2]];
    end else if (expD && !dWeV) begin
      refPend = 2; refPendData = sram[dAddrV[9:2]];
    end
    if (!iReq || expIf) refRun = 0;
    else if (expD && refRun < MaxRun) refRun++;
    if (expStall) refStallCnt++;
    lastIfGnt = expIf;
    lastDGnt  = expD;
  endtask

  logic        rIf, rD, rWe;
  logic [15:0] rIfAddr, rDAddr;
  logic [31:0] rWdata;
  logic [3:0]  rMask;

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = $urandom;
    mem_rdata = '0;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2000; d_wdata = '0; d_bmask = 4'h0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("rst_if_gnt", 64'(if_gnt), 64'd0);
    checkOutput("rst_d_gnt", 64'(d_gnt), 64'd0);
    checkOutput("rst_mem_ce", 64'(mem_ce), 64'd0);
    checkOutput("rst_stall", 64'(core_stall), 64'd0);
    checkOutput("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fetch only");
    repeat (3) applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("[TB] conflict");
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h2000, 32'h0, 4'h0);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("[TB] starvation");
    repeat (12) applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0044, 32'h0, 4'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("[TB] write");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0103, 32'hAABBCCDD, 4'b0010);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0100, 32'h0, 4'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("[TB] reset during read");
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 32'h0, 4'h0);
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    refPend = 0; refRun = 0; refStallCnt = '0;
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("[TB] random traffic");
    rIf = 1'b0; rD = 1'b0; rWe = 1'b0;
    rIfAddr = '0; rDAddr = '0; rWdata = '0; rMask = '0;
    for (int n = 0; n < 400; n++) begin
      if (!rIf || lastIfGnt || $urandom_range(0, 7) == 0) begin
        rIf = ($urandom_range(0, 9) < 7);
        rIfAddr = 16'($urandom_range(0, 16'h03FF));
      end
      if (!rD || lastDGnt || $urandom_range(0, 7) == 0) begin
        rD = ($urandom_range(0, 9) < 7);
        rWe = ($urandom_range(0, 3) == 0);
        rDAddr = 16'($urandom_range(0, 16'h03FF));
        rWdata = $urandom;
        rMask = 4'($urandom_range(0, 15));
      end
      applyStimulus(rIf, rIfAddr, rD, rWe, rDAddr, rWdata, rMask);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port synchronous SRAM between the core's instruction-fetch port and its load/store port. Fetch and LSU are the two requesters; the SRAM is the shared resource. The block issues at most one memory access per cycle and routes each read response back to the requester that issued it. It also raises a stall to the core while any request is waiting, and counts stall cycles for debug.

Parameters:
AW, 16, byte-address width of both requester ports
DW, 32, data width; fixed at 32, so bmask is 4 bits
MAX_DATA_RUN, 4, maximum consecutive data grants while fetch is waiting; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request
if_addr  in  AW  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DW  fetch read data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data byte address
d_wdata  in  DW  write data
d_bmask  in  4  byte-lane write enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DW  load data
mem_ce  out  1  SRAM chip enable
mem_we  out  1  SRAM write enable
mem_addr  out  AW-2  SRAM word address
mem_wdata  out  DW  SRAM write data
mem_bmask  out  4  SRAM byte enables
mem_rdata  in  DW  SRAM read data; valid the cycle after a read with mem_ce=1 and mem_we=0
core_stall  out  1  core must hold PC and must not commit this cycle
stall_cnt  out  32  count of cycles with core_stall=1

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low. All state resets to 0.
- Grant path:
  - Grants are combinational, in the same cycle as the request.
  - if_gnt and d_gnt are never both 1.
  - mem_ce = if_gnt | d_gnt.
- Requester rules: a requester holds req, addr, we, wdata and bmask stable until its gnt. Deasserting before gnt is legal; the request is simply withdrawn.
- Memory outputs:
  - On a fetch grant: mem_we=0, mem_addr=if_addr[AW-1:2], mem_bmask=4'hF.
  - On a data grant: mem_we=d_we, mem_addr=d_addr[AW-1:2], mem_wdata=d_wdata, mem_bmask=d_bmask.
  - Address bits [1:0] are ignored.
  - With no grant: mem_we=0 and mem_bmask=0.
- Arbitration:
  - One requester active: it is granted.
  - Both active: data wins unless data_run == MAX_DATA_RUN, in which case fetch wins.
- data_run counter (4-bit):
  - +1 on each data grant while if_req=1.
  - Cleared on a fetch grant, or in any cycle with if_req=0.
  - Saturates at MAX_DATA_RUN.
- Response FSM, states RSP_IDLE, RSP_FETCH, RSP_DATA:
  - Next state follows the grant in the current cycle: fetch grant -> RSP_FETCH; data read grant -> RSP_DATA; data write or no grant -> RSP_IDLE.
  - This applies from every state, so back-to-back grants are fully pipelined at one access per cycle.
  - In RSP_FETCH: if_rvalid=1, if_rdata=mem_rdata.
  - In RSP_DATA: d_rvalid=1, d_rdata=mem_rdata.
  - rdata buses are 0 when the matching rvalid=0.
  - Writes produce no rvalid; a write completes at its grant.
- core_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt). Combinational.
- stall_cnt increments on each cycle with core_stall=1; wraps at 2^32-1 -> 0.
- Reset values: all outputs 0, FSM in RSP_IDLE, data_run=0, stall_cnt=0.
- Reset mid-operation: a pending response is dropped; no rvalid appears after rst_n rises until a new read is granted.
- Simultaneous events:
  - Fetch grant in the cycle a data response is returned is legal; the data response still appears on d_rvalid.
  - A fetch stall while data_run is saturated is resolved in the very next arbitration.

Test Plan:
- Reset: hold rst_n=0 with both requesters active -> all outputs 0, including gnt, rvalid and stall_cnt. Release -> arbitration starts next edge.
- Fetch only: if_req=1, if_addr=0x0010 for 3 cycles -> if_gnt=1 each cycle, mem_addr=0x0004, if_rvalid=1 one cycle after each grant, core_stall=0.
- Conflict: if_req=1 and d_req=1 read at 0x2000 -> d_gnt=1, if_gnt=0, core_stall=1, stall_cnt=1. Next cycle d_req=0 -> if_gnt=1, d_rvalid=1 with d_rdata=mem_rdata.
- Starvation, MAX_DATA_RUN=4: d_req and if_req held high -> 4 d_gnt cycles, then 1 if_gnt, then d_gnt again; the pattern repeats.
- Write: d_we=1, d_addr=0x0103, d_bmask=4'b0010, d_wdata=0xAABBCCDD -> mem_we=1, mem_addr=0x0040, mem_bmask=4'b0010, and no d_rvalid follows.
- Reset mid-read: data read granted, rst_n pulsed low before the next edge -> d_rvalid stays 0 and the FSM is in RSP_IDLE after release.
